gen_scheduler: RTL and testbench

//  Sequences Game of Life generations against the display frame rate.

---
 rtl/gen_scheduler.sv | 115 +++++++++++
 tb/tb_gen_scheduler.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/gen_scheduler.sv
// Paces Game of Life generations to display frames: launches life_logic, waits for done, swaps banks on a frame tick.
// Latency: start one cycle after the launching tick; bank swap lands in the cycle after a tick. No backpressure; late done sets sticky overrun.
module gen_scheduler #(
    parameter int LOG_MAX_SPEED = 3,
    parameter int GEN_WIDTH     = 16
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     vsync_in,
    input  logic [LOG_MAX_SPEED-1:0] speed_in,
    input  logic                     pause_in,
    input  logic                     step_in,
    input  logic                     logic_done_in,
    output logic                     start_out,
    output logic                     buf_sel_out,
    output logic                     busy_out,
    output logic [GEN_WIDTH-1:0]     gen_count_out,
    output logic                     overrun_out
);

    localparam int CW = LOG_MAX_SPEED + 1;
    localparam logic [CW-1:0] MAX_FRAMES = {1'b1, {LOG_MAX_SPEED{1'b0}}};

    typedef enum logic [1:0] {
        WAIT_FRAMES,
        LAUNCH,
        COMPUTE,
        WAIT_SWAP
    } state_t;

    state_t                 state_q;
    logic                   vs_q;
    logic [CW-1:0]          frame_cnt_q;
    logic                   start_q;
    logic                   buf_sel_q;
    logic [GEN_WIDTH-1:0]   gen_q;
    logic                   overrun_q;

    logic                   tick;
    logic [CW-1:0]          fpg;
    logic [CW-1:0]          cnt_inc;
    logic                   swap;
    logic                   relaunch;

    assign tick     = vs_q & ~vsync_in;
    assign fpg      = MAX_FRAMES - {1'b0, speed_in};
    assign cnt_inc  = (frame_cnt_q == MAX_FRAMES) ? MAX_FRAMES : frame_cnt_q + 1'b1;
    // A done arriving on the tick itself swaps immediately rather than waiting a whole frame.
    assign swap     = tick & (((state_q == COMPUTE) & logic_done_in) | (state_q == WAIT_SWAP));
    assign relaunch = ~pause_in & (fpg == CW'(1));

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= WAIT_FRAMES;
            vs_q        <= 1'b1;
            frame_cnt_q <= '0;
            start_q     <= 1'b0;
            buf_sel_q   <= 1'b0;
            gen_q       <= '0;
            overrun_q   <= 1'b0;
        end else begin
            vs_q    <= vsync_in;
            start_q <= 1'b0;
            if (swap) begin
                buf_sel_q <= ~buf_sel_q;
                gen_q     <= gen_q + 1'b1;
                // The swap tick is frame 1 of the next period.
                if (relaunch) begin
                    frame_cnt_q <= '0;
                    state_q     <= LAUNCH;
                    start_q     <= 1'b1;
                end else begin
                    frame_cnt_q <= CW'(1);
                    state_q     <= WAIT_FRAMES;
                end
            end else begin
                case (state_q)
                    WAIT_FRAMES: begin
                        if (pause_in) begin
                            if (step_in) begin
                                state_q <= LAUNCH;
                                start_q <= 1'b1;
                            end
                        end else if (tick) begin
                            if (cnt_inc >= fpg) begin
                                frame_cnt_q <= '0;
                                state_q     <= LAUNCH;
                                start_q     <= 1'b1;
                            end else begin
                                frame_cnt_q <= cnt_inc;
                            end
                        end
                    end
                    LAUNCH: state_q <= COMPUTE;
                    COMPUTE: begin
                        if (logic_done_in) begin
                            state_q <= WAIT_SWAP;
                        end else if (tick) begin
                            overrun_q <= 1'b1;
                        end
                    end
                    WAIT_SWAP: state_q <= WAIT_SWAP;
                    default:   state_q <= WAIT_FRAMES;
                endcase
            end
        end
    end

    assign start_out     = start_q;
    assign buf_sel_out   = buf_sel_q;
    assign busy_out      = (state_q != WAIT_FRAMES);
    assign gen_count_out = gen_q;
    assign overrun_out   = overrun_q;

endmodule

// File: tb/tb_gen_scheduler.sv
// Directed bench for gen_scheduler: per-cycle vector table plus reset, free-running and async-reset sequences.
module tb_gen_scheduler;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        vsync_in;
    logic [2:0]  speed_in;
    logic        pause_in;
    logic        step_in;
    logic        logic_done_in;
    logic        start_out;
    logic        buf_sel_out;
    logic        busy_out;
    logic [15:0] gen_count_out;
    logic        overrun_out;

    int n_checks = 0;
    int n_fail   = 0;

    gen_scheduler #(.LOG_MAX_SPEED(3), .GEN_WIDTH(16)) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .vsync_in      (vsync_in),
        .speed_in      (speed_in),
        .pause_in      (pause_in),
        .step_in       (step_in),
        .logic_done_in (logic_done_in),
        .start_out     (start_out),
        .buf_sel_out   (buf_sel_out),
        .busy_out      (busy_out),
        .gen_count_out (gen_count_out),
        .overrun_out   (overrun_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        vs;
        logic [2:0]  speed;
        logic        pause;
        logic        step;
        logic        done;
        logic        e_start;
        logic        e_busy;
        logic        e_buf;
        logic [15:0] e_gen;
        logic        e_ovr;
    } vec_t;

    localparam int NV = 31;
    vec_t tbl [NV];

    function automatic vec_t mk(logic vs, logic [2:0] sp, logic pa, logic st, logic dn,
                                logic es, logic eb, logic ebuf, logic [15:0] eg, logic eo);
        vec_t v;
        v.vs = vs; v.speed = sp; v.pause = pa; v.step = st; v.done = dn;
        v.e_start = es; v.e_busy = eb; v.e_buf = ebuf; v.e_gen = eg; v.e_ovr = eo;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic es, input logic eb, input logic ebuf,
                           input logic [15:0] eg, input logic eo);
        chk({tag, ".start"},   32'(start_out),     32'(es));
        chk({tag, ".busy"},    32'(busy_out),      32'(eb));
        chk({tag, ".buf_sel"}, 32'(buf_sel_out),   32'(ebuf));
        chk({tag, ".gen"},     32'(gen_count_out), 32'(eg));
        chk({tag, ".overrun"}, 32'(overrun_out),   32'(eo));
    endtask

    initial begin
        int starts;
        int toggles;
        int dcnt;
        logic prev_buf;

        // Columns: vsync speed pause step done | start busy buf gen overrun
        tbl[0]  = mk(1, 5, 0, 0, 0,  0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 5, 0, 0, 0,  0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 5, 0, 0, 0,  0, 0, 0, 0, 0);
        tbl[3]  = mk(0, 5, 0, 0, 0,  0, 0, 0, 0, 0);
        tbl[4]  = mk(1, 5, 0, 0, 0,  0, 0, 0, 0, 0);
        tbl[5]  = mk(0, 5, 0, 0, 0,  1, 1, 0, 0, 0);
        tbl[6]  = mk(1, 5, 0, 0, 0,  0, 1, 0, 0, 0);
        tbl[7]  = mk(1, 5, 0, 0, 1,  0, 1, 0, 0, 0);
        tbl[8]  = mk(0, 5, 0, 0, 0,  0, 0, 1, 1, 0);
        tbl[9]  = mk(1, 7, 0, 0, 0,  0, 0, 1, 1, 0);
        tbl[10] = mk(0, 7, 0, 0, 0,  1, 1, 1, 1, 0);
        tbl[11] = mk(1, 7, 0, 0, 0,  0, 1, 1, 1, 0);
        tbl[12] = mk(0, 7, 0, 0, 1,  1, 1, 0, 2, 0);
        tbl[13] = mk(1, 7, 0, 0, 0,  0, 1, 0, 2, 0);
        tbl[14] = mk(1, 7, 0, 0, 1,  0, 1, 0, 2, 0);
        tbl[15] = mk(1, 7, 1, 0, 0,  0, 1, 0, 2, 0);
        tbl[16] = mk(0, 7, 1, 0, 0,  0, 0, 1, 3, 0);
        tbl[17] = mk(1, 7, 1, 0, 0,  0, 0, 1, 3, 0);
        tbl[18] = mk(0, 7, 1, 0, 0,  0, 0, 1, 3, 0);
        tbl[19] = mk(1, 7, 1, 1, 0,  1, 1, 1, 3, 0);
        tbl[20] = mk(1, 7, 1, 1, 0,  0, 1, 1, 3, 0);
        tbl[21] = mk(1, 7, 1, 1, 0,  0, 1, 1, 3, 0);
        tbl[22] = mk(0, 7, 1, 0, 0,  0, 1, 1, 3, 1);
        tbl[23] = mk(1, 7, 1, 0, 1,  0, 1, 1, 3, 1);
        tbl[24] = mk(1, 7, 1, 0, 1,  0, 1, 1, 3, 1);
        tbl[25] = mk(0, 7, 1, 0, 0,  0, 0, 0, 4, 1);
        tbl[26] = mk(1, 5, 0, 0, 0,  0, 0, 0, 4, 1);
        tbl[27] = mk(0, 5, 0, 0, 0,  0, 0, 0, 4, 1);
        tbl[28] = mk(1, 5, 0, 1, 1,  0, 0, 0, 4, 1);
        tbl[29] = mk(0, 5, 0, 0, 0,  1, 1, 0, 4, 1);
        tbl[30] = mk(1, 5, 0, 0, 0,  0, 1, 0, 4, 1);

        rst_n_in = 1'b0; vsync_in = 1'b1; speed_in = 3'd5;
        pause_in = 1'b0; step_in = 1'b0; logic_done_in = 1'b0;

        // Reset held while vsync toggles: outputs stay cleared.
        for (int i = 0; i < 4; i++) begin
            vsync_in = i[0];
            cyc();
            chk_all($sformatf("rst%0d", i), 0, 0, 0, 16'd0, 0);
        end
        vsync_in = 1'b1;
        cyc();
        rst_n_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("post_rst%0d.start", i), 32'(start_out), 32'd0);
        end

        for (int i = 0; i < NV; i++) begin
            vsync_in = tbl[i].vs; speed_in = tbl[i].speed; pause_in = tbl[i].pause;
            step_in = tbl[i].step; logic_done_in = tbl[i].done;
            cyc();
            chk_all($sformatf("row%0d", i), tbl[i].e_start, tbl[i].e_busy, tbl[i].e_buf,
                    tbl[i].e_gen, tbl[i].e_ovr);
        end
        vsync_in = 1'b1; step_in = 1'b0; logic_done_in = 1'b0;

        // Async reset in COMPUTE clears state immediately, without a clock edge.
        #2;
        rst_n_in = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 0, 16'd0, 0);
        cyc();
        rst_n_in = 1'b1;
        cyc();

        // Free run at fpg=1, 200-cycle frames, done 100 cycles after each start.
        speed_in = 3'd7;
        starts = 0; toggles = 0; dcnt = 0; prev_buf = buf_sel_out;
        for (int c = 0; c < 1000; c++) begin
            vsync_in = ((c % 200) == 199) ? 1'b0 : 1'b1;
            logic_done_in = (dcnt == 1);
            if (dcnt > 0) dcnt--;
            cyc();
            if (start_out) begin
                starts++;
                dcnt = 100;
            end
            if (buf_sel_out != prev_buf) toggles++;
            prev_buf = buf_sel_out;
        end
        vsync_in = 1'b1; logic_done_in = 1'b0;
        chk("run.starts",  32'(starts),        32'd5);
        chk("run.toggles", 32'(toggles),       32'd4);
        chk("run.gen",     32'(gen_count_out), 32'd4);
        chk("run.overrun", 32'(overrun_out),   32'd0);
        chk("run.busy",    32'(busy_out),      32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
